// File: rtl/note_judge_pkg.sv
// Shared types and arithmetic helpers for the note lane judge.
package note_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest song pattern the popcount helper accepts (LANES*DEPTH must fit).
  localparam int POP_W = 1024;

  // a + b, clamped to maxv.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned maxv);
    int unsigned s;
    s = a + b;
    return (s > maxv) ? maxv : s;
  endfunction

  // a - b, clamped to 0.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) n += {31'd0, v[i]};
    return n;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/note_lane_judge_lane_shifter.sv
// One scrolling note lane: load, hit-window search/clear, shift, per-cycle flags.
module lane_shifter #(
  parameter int DEPTH      = 26,
  parameter int HIT_WINDOW = 2
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             load,
  input  logic [DEPTH-1:0] load_bits,
  input  logic             active,
  input  logic             step,
  input  logic             press_edge,
  output logic [DEPTH-1:0] lane,
  output logic             hit,
  output logic             bad,
  output logic             miss
);

  logic [DEPTH-1:0] hit_mask;
  logic [DEPTH-1:0] kept;
  logic [DEPTH-1:0] nxt;
  logic             found;

  // Judge against pre-shift contents: the highest-index note in the window wins,
  // and a note hit this cycle can no longer fall off as a miss.
  always_comb begin
    hit_mask = '0;
    for (int i = DEPTH - HIT_WINDOW; i < DEPTH; i++) begin
      if (lane[i]) begin
        hit_mask    = '0;
        hit_mask[i] = 1'b1;
      end
    end
    found = |hit_mask;
    hit   = active & press_edge & found;
    bad   = active & press_edge & ~found;
    kept  = hit ? (lane & ~hit_mask) : lane;
    miss  = active & step & kept[DEPTH-1];
    nxt   = step ? {kept[DEPTH-2:0], 1'b0} : kept;
  end

  // Load wins over play; outside play the lane is frozen.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b)    lane <= '0;
    else if (load)   lane <= load_bits;
    else if (active) lane <= nxt;
  end

endmodule

// File: rtl/note_lane_judge.sv
// Note lane judge top: press conditioning, lanes, judgement reduction, counters, FSM.
module note_lane_judge
  import note_judge_pkg::*;
#(
  parameter int LANES      = 3,
  parameter int DEPTH      = 26,
  parameter int HIT_WINDOW = 2,
  parameter int SCORE_W    = 8,
  parameter int CNT_W      = 7
) (
  input  logic                   clock,
  input  logic                   reset_b,
  input  logic                   load,
  input  logic [LANES*DEPTH-1:0] song_pattern,
  input  logic                   step,
  input  logic [LANES-1:0]       press,
  output logic [LANES*DEPTH-1:0] lane_view,
  output logic [LANES-1:0]       lane_head,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     combo,
  output logic [SCORE_W-1:0]     max_combo,
  output logic [CNT_W-1:0]       notes_remaining,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic [1:0]             state
);

  localparam int unsigned SMAX = (32'd1 << SCORE_W) - 32'd1;

  state_t           st;
  logic [LANES-1:0] sync1, sync2, sync3;
  logic [LANES-1:0] press_edge;
  logic [LANES-1:0] hit_v, bad_v, miss_v;
  logic             active;
  int unsigned      h_n, b_n, m_n;
  int unsigned      score_n, combo_n, maxc_n, notes_n;

  assign state      = st;
  assign active     = (st == ST_PLAY) && !load;
  assign press_edge = sync2 & ~sync3;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= press;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_shifter #(.DEPTH(DEPTH), .HIT_WINDOW(HIT_WINDOW)) u_lane (
      .clock      (clock),
      .reset_b    (reset_b),
      .load       (load),
      .load_bits  (song_pattern[l*DEPTH +: DEPTH]),
      .active     (active),
      .step       (step),
      .press_edge (press_edge[l]),
      .lane       (lane_view[l*DEPTH +: DEPTH]),
      .hit        (hit_v[l]),
      .bad        (bad_v[l]),
      .miss       (miss_v[l])
    );
    assign lane_head[l] = lane_view[l*DEPTH + DEPTH - 1];
  end

  // Reduce lane flags to counts and form next counter values.
  always_comb begin
    h_n = 0;
    b_n = 0;
    m_n = 0;
    for (int l = 0; l < LANES; l++) begin
      h_n += {31'd0, hit_v[l]};
      b_n += {31'd0, bad_v[l]};
      m_n += {31'd0, miss_v[l]};
    end
    if (h_n >= b_n) score_n = sat_add(32'(score), h_n - b_n, SMAX);
    else            score_n = sat_sub(32'(score), b_n - h_n);
    if (b_n + m_n > 0) combo_n = sat_add(32'd0, h_n, SMAX);
    else               combo_n = sat_add(32'(combo), h_n, SMAX);
    maxc_n  = max_u(32'(max_combo), combo_n);
    notes_n = 32'(notes_remaining) - h_n - m_n;
  end

  // Play-state machine with registered counters and pulses.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      st              <= ST_IDLE;
      score           <= '0;
      combo           <= '0;
      max_combo       <= '0;
      notes_remaining <= '0;
      hit_pulse       <= 1'b0;
      miss_pulse      <= 1'b0;
    end else if (load) begin
      st              <= ST_PLAY;
      score           <= '0;
      combo           <= '0;
      max_combo       <= '0;
      notes_remaining <= CNT_W'(popcount(POP_W'(song_pattern)));
      hit_pulse       <= 1'b0;
      miss_pulse      <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (st == ST_PLAY) begin
        score           <= SCORE_W'(score_n);
        combo           <= SCORE_W'(combo_n);
        max_combo       <= SCORE_W'(maxc_n);
        notes_remaining <= CNT_W'(notes_n);
        hit_pulse       <= (h_n > 0);
        miss_pulse      <= (b_n + m_n > 0);
        if (notes_remaining == '0) st <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_note_lane_judge.sv
// Scoreboard bench for note_lane_judge: stimulus pushes expected counter
// snapshots, a monitor pops one per output pulse.
module tb_note_lane_judge;

  localparam int LANES = 3;
  localparam int DEPTH = 26;
  localparam int W     = LANES * DEPTH;

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] combo;
    logic [7:0] maxc;
    logic [6:0] notes;
    logic       hit;
    logic       miss;
  } exp_t;

  logic             clock, reset_b, load, step;
  logic [W-1:0]     song_pattern;
  logic [LANES-1:0] press;
  logic [W-1:0]     lane_view;
  logic [LANES-1:0] lane_head;
  logic [7:0]       score, combo, max_combo;
  logic [6:0]       notes_remaining;
  logic             hit_pulse, miss_pulse;
  logic [1:0]       state;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  note_lane_judge #(.LANES(3), .DEPTH(26), .HIT_WINDOW(2), .SCORE_W(8), .CNT_W(7)) dut (
    .clock           (clock),
    .reset_b         (reset_b),
    .load            (load),
    .song_pattern    (song_pattern),
    .step            (step),
    .press           (press),
    .lane_view       (lane_view),
    .lane_head       (lane_head),
    .score           (score),
    .combo           (combo),
    .max_combo       (max_combo),
    .notes_remaining (notes_remaining),
    .hit_pulse       (hit_pulse),
    .miss_pulse      (miss_pulse),
    .state           (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] note(input int l, input int s);
    logic [W-1:0] v;
    v = '0;
    v[l*DEPTH + s] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int s, input int c, input int m, input int n,
                      input logic h, input logic mi);
    exp_t e;
    e.score = 8'(s);
    e.combo = 8'(c);
    e.maxc  = 8'(m);
    e.notes = 7'(n);
    e.hit   = h;
    e.miss  = mi;
    q.push_back(e);
  endtask

  task automatic pulse_load(input logic [W-1:0] p);
    song_pattern = p;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic press_lane(input logic [LANES-1:0] mask);
    press = press | mask;
    repeat (4) tick();
    press = press & ~mask;
    repeat (2) tick();
  endtask

  // Wait for all expected pulses to be consumed; a stuck queue is a failure.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d expected pulses never seen", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: every judgement pulse must match the oldest expected snapshot.
  always @(negedge clock) begin
    if (reset_b && (hit_pulse || miss_pulse)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got hit=%0b miss=%0b score=%0d combo=%0d want no pulse",
                 hit_pulse, miss_pulse, score, combo);
      end else begin
        exp_t e, a;
        e = q.pop_front();
        a = {score, combo, max_combo, notes_remaining, hit_pulse, miss_pulse};
        if (a !== e) begin
          bad++;
          $display("FAIL judge: got s=%0d c=%0d mx=%0d n=%0d h=%0b m=%0b want s=%0d c=%0d mx=%0d n=%0d h=%0b m=%0b",
                   a.score, a.combo, a.maxc, a.notes, a.hit, a.miss,
                   e.score, e.combo, e.maxc, e.notes, e.hit, e.miss);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; load = 1'b0; step = 1'b0; press = '0; song_pattern = '0;
    repeat (3) @(posedge clock);
    #1 reset_b = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_counters", 128'({score, combo, max_combo, notes_remaining}), 128'(0));
    chk("rst_lanes", 128'(lane_view), 128'(0));
    chk("rst_pulses", 128'({hit_pulse, miss_pulse}), 128'(0));
    tick();

    // Load single note at the judgement line
    pulse_load(note(0, 25));
    @(negedge clock);
    chk("load_state", 128'(state), 128'(1));
    chk("load_notes", 128'(notes_remaining), 128'(1));
    chk("load_head", 128'(lane_head), 128'(3'b001));
    tick();

    // Hit with no step, then DONE
    push(1, 1, 1, 0, 1'b1, 1'b0);
    press_lane(3'b001);
    drain("hit_single");
    repeat (2) tick();
    @(negedge clock);
    chk("done_after_hit", 128'(state), 128'(2));
    tick();

    // Miss by stepping the note off the end
    pulse_load(note(0, 25));
    push(0, 0, 0, 0, 1'b0, 1'b1);
    do_step();
    drain("miss_step");
    repeat (2) tick();
    @(negedge clock);
    chk("done_after_miss", 128'(state), 128'(2));
    tick();

    // Window edge: slot 23 is a bad press (score stays 0), slot 24 is a hit
    pulse_load(note(0, 24) | note(1, 23));
    push(0, 0, 0, 2, 1'b0, 1'b1);
    press_lane(3'b010);
    drain("bad_press");
    push(1, 1, 1, 1, 1'b1, 1'b0);
    press_lane(3'b001);
    drain("hit_slot24");
    @(negedge clock);
    chk("window_lanes", 128'(lane_view), 128'(note(1, 23)));
    chk("window_state", 128'(state), 128'(1));
    tick();

    // Build combo 5, then simultaneous hit (lane1) and bad press (lane2)
    pulse_load(note(0, 25) | note(0, 24) | note(0, 23) | note(1, 25) | note(1, 24) | note(1, 22));
    push(1, 1, 1, 5, 1'b1, 1'b0); press_lane(3'b001); drain("combo1");
    push(2, 2, 2, 4, 1'b1, 1'b0); press_lane(3'b001); drain("combo2");
    push(3, 3, 3, 3, 1'b1, 1'b0); press_lane(3'b010); drain("combo3");
    push(4, 4, 4, 2, 1'b1, 1'b0); press_lane(3'b010); drain("combo4");
    do_step();
    push(5, 5, 5, 1, 1'b1, 1'b0); press_lane(3'b001); drain("combo5");
    do_step();
    push(5, 1, 5, 0, 1'b1, 1'b1); press_lane(3'b110); drain("hit_and_bad");
    repeat (2) tick();
    @(negedge clock);
    chk("combo_done", 128'(state), 128'(2));
    tick();

    // Held press across three steps gives one judgement
    pulse_load(note(1, 25) | note(2, 0));
    push(1, 1, 1, 1, 1'b1, 1'b0);
    press[1] = 1'b1;
    repeat (10) tick();
    do_step();
    repeat (30) tick();
    do_step();
    repeat (30) tick();
    do_step();
    repeat (27) tick();
    press[1] = 1'b0;
    drain("held_press");
    repeat (4) tick();
    @(negedge clock);
    chk("held_lanes", 128'(lane_view), 128'(note(2, 3)));
    chk("held_score", 128'({score, notes_remaining}), 128'({8'd1, 7'd1}));
    tick();

    // Load coinciding with step and a press edge: pattern loaded untouched
    press[0] = 1'b1;
    tick();
    tick();
    song_pattern = note(0, 25);
    load = 1'b1;
    step = 1'b1;
    tick();
    load = 1'b0;
    step = 1'b0;
    @(negedge clock);
    chk("load_prio_lanes", 128'(lane_view), 128'(note(0, 25)));
    chk("load_prio_cnt", 128'({state, score, notes_remaining}), 128'({2'd1, 8'd0, 7'd1}));
    tick();
    press[0] = 1'b0;
    repeat (5) tick();
    push(0, 0, 0, 0, 1'b0, 1'b1);
    do_step();
    drain("load_prio_miss");

    // Reset mid-play clears everything immediately
    pulse_load(note(0, 25) | note(1, 25));
    push(1, 1, 1, 1, 1'b1, 1'b0);
    press_lane(3'b001);
    drain("pre_reset_hit");
    #2 reset_b = 1'b0;
    #1;
    chk("midrst_state", 128'(state), 128'(0));
    chk("midrst_counters", 128'({score, combo, max_combo, notes_remaining}), 128'(0));
    chk("midrst_lanes", 128'({lane_view, hit_pulse, miss_pulse}), 128'(0));
    tick();
    reset_b = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
